mem_bus_sequencer: RTL and testbench



---
 rtl/mem_bus_sequencer_if.sv | 14 +
 rtl/mem_bus_sequencer.sv | 89 ++++++++
 tb/tb_mem_bus_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_sequencer_if.sv
// mem_bus_sequencer_if: shared memory-slave bus between the sequencer (master) and the peripheral decode (slave)
interface mem_bus_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: serialises one CPU data access plus one instruction fetch per step onto a shared bus
// Define MEM_BUS_SEQ_IBUF_EN to add a one-entry instruction buffer that skips the bus on a repeated fetch.
module mem_bus_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       iaddr_i,
    output logic [DW-1:0]       iin_o,
    input  logic [AW-1:0]       daddr_i,
    input  logic [DW-1:0]       dout_i,
    output logic [DW-1:0]       din_o,
    input  logic [1:0]          drw_i,
    output logic                cpu_stall_o,
    mem_bus_sequencer_if.master bus
);
    typedef enum logic [1:0] {DATA, FETCH, RELEASE} state_e;
    state_e        state_q;
    logic          cpu_stall_q;
    logic [DW-1:0] iin_q;
    logic [DW-1:0] din_q;
    logic          hit;
    logic [DW-1:0] hit_word;
    logic          in_data;
    logic          in_fetch;
    logic          ack;
`ifdef MEM_BUS_SEQ_IBUF_EN
    logic          ibuf_v_q;
    logic [AW-1:0] ibuf_a_q;
    logic [DW-1:0] ibuf_d_q;
    assign hit      = ibuf_v_q && ibuf_a_q == iaddr_i;
    assign hit_word = ibuf_d_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_v_q <= 1'b0;
        end else if (state_q == FETCH && ack) begin
            ibuf_v_q <= 1'b1;
            ibuf_a_q <= iaddr_i;
            ibuf_d_q <= bus.mem_rdata;
        end else if (state_q == DATA && ack && drw_i[1] && daddr_i == ibuf_a_q) begin
            ibuf_v_q <= 1'b0;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif
    // Bus outputs are forced to their idle values while rst is held so an abandoned request drops at once.
    assign in_data       = !rst && state_q == DATA;
    assign in_fetch      = !rst && state_q == FETCH;
    assign bus.mem_req   = in_data || (in_fetch && !hit);
    assign bus.mem_we    = in_data && drw_i[1];
    assign bus.mem_addr  = in_data ? daddr_i : in_fetch ? iaddr_i : '0;
    assign bus.mem_wdata = in_data ? dout_i : '0;
    assign ack           = bus.mem_req && bus.mem_ack;
    assign cpu_stall_o   = cpu_stall_q;
    assign iin_o         = iin_q;
    assign din_o         = din_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            cpu_stall_q <= 1'b1;
            iin_q       <= '0;
            din_q       <= '0;
        end else begin
            case (state_q)
                DATA: begin
                    if (ack) begin
                        if (drw_i == 2'b01) din_q <= bus.mem_rdata;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (ack || hit) begin
                        iin_q       <= ack ? bus.mem_rdata : hit_word;
                        state_q     <= RELEASE;
                        cpu_stall_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_q     <= drw_i != 2'b00 ? DATA : FETCH;
                    cpu_stall_q <= 1'b1;
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer: randomized step-level checks of mem_bus_sequencer against a behavioural CPU-step model
module tb_mem_bus_sequencer;
`ifdef MEM_BUS_SEQ_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iaddr_i = '0;
    logic [31:0] iin_o;
    logic [31:0] daddr_i = '0;
    logic [31:0] dout_i = '0;
    logic [31:0] din_o;
    logic [1:0]  drw_i = '0;
    logic        cpu_stall_o;
    int          n_cmp = 0;
    int          n_fail = 0;
    // slave model state
    int          cnt = 0;
    logic [1:0]  xi = '0;
    int          lat_d = 0;
    int          lat_f = 0;
    logic        has_data = 1'b0;
    logic        stray = 1'b0;
    logic [31:0] rdat_d = '0;
    logic [31:0] rdat_f = '0;
    // reference model state
    logic [31:0] exp_iin = '0;
    logic [31:0] exp_din = '0;
    bit          buf_v = 1'b0;
    logic [31:0] buf_a = '0;
    logic [31:0] buf_d = '0;
    mem_bus_sequencer_if #(.AW(32), .DW(32)) bus ();
    mem_bus_sequencer #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .iaddr_i(iaddr_i), .iin_o(iin_o), .daddr_i(daddr_i),
        .dout_i(dout_i), .din_o(din_o), .drw_i(drw_i), .cpu_stall_o(cpu_stall_o), .bus(bus)
    );
    always #5 clk = ~clk;
    wire data_ph = has_data && xi == 2'd0;
    assign bus.mem_ack   = (bus.mem_req && cnt == (data_ph ? lat_d : lat_f)) || stray;
    assign bus.mem_rdata = data_ph ? rdat_d : rdat_f;
    always @(posedge clk) begin
        cnt <= (!bus.mem_req || bus.mem_ack) ? 0 : cnt + 1;
        xi  <= rst ? 2'd0 : (bus.mem_req && bus.mem_ack) ? xi + 2'd1 : !cpu_stall_o ? 2'd0 : xi;
    end
    // One CPU step: entered at a negedge inside RELEASE (or right after reset release), ends in the next RELEASE.
    task automatic run_step(input bit ar, input logic [1:0] drw, input logic [31:0] da, input logic [31:0] dd,
                            input logic [31:0] ia, input logic [31:0] rd, input logic [31:0] rf,
                            input int ld, input int lf);
        bit          hd;
        bit          hit;
        int          nd;
        int          nf;
        bit          rel;
        bit          req;
        bit          ewe;
        logic [31:0] ea;
        hd = !ar && drw != 2'b00;
        if (hd && drw[1] && buf_a == da) buf_v = 1'b0;
        hit = IBUF && buf_v && buf_a == ia;
        nd = hd ? ld : 0;
        nf = hit ? 1 : lf;
        drw_i = drw; daddr_i = da; dout_i = dd; iaddr_i = ia;
        rdat_d = rd; rdat_f = rf; has_data = hd; lat_d = ld - 1; lat_f = lf - 1;
        if (ar) #1;
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int c = 1; c <= nd + nf + 1; c++) begin
            if (c > 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            stray = 1'b0;
            rel = c == nd + nf + 1;
            req = !rel && !(hit && c > nd);
            ea  = c <= nd ? da : ia;
            ewe = c <= nd && drw[1];
            n_cmp++;
            if (cpu_stall_o !== !rel) begin
                n_fail++;
                $display("FAIL stall cyc%0d: got %b exp %b", c, cpu_stall_o, !rel);
            end
            n_cmp++;
            if (bus.mem_req !== req) begin
                n_fail++;
                $display("FAIL mem_req cyc%0d: got %b exp %b", c, bus.mem_req, req);
            end
            if (req) begin
                n_cmp++;
                if (bus.mem_addr !== ea) begin
                    n_fail++;
                    $display("FAIL mem_addr cyc%0d: got %h exp %h", c, bus.mem_addr, ea);
                end
                n_cmp++;
                if (bus.mem_we !== ewe) begin
                    n_fail++;
                    $display("FAIL mem_we cyc%0d: got %b exp %b", c, bus.mem_we, ewe);
                end
                if (ewe) begin
                    n_cmp++;
                    if (bus.mem_wdata !== dd) begin
                        n_fail++;
                        $display("FAIL mem_wdata cyc%0d: got %h exp %h", c, bus.mem_wdata, dd);
                    end
                end
            end
        end
        if (hd && drw == 2'b01) exp_din = rd;
        exp_iin = hit ? buf_d : rf;
        if (!hit) begin
            buf_v = 1'b1; buf_a = ia; buf_d = rf;
        end
        n_cmp++;
        if (iin_o !== exp_iin) begin
            n_fail++;
            $display("FAIL iin: got %h exp %h", iin_o, exp_iin);
        end
        n_cmp++;
        if (din_o !== exp_din) begin
            n_fail++;
            $display("FAIL din: got %h exp %h", din_o, exp_din);
        end
        stray = 1'($urandom_range(0, 1));
    endtask
    task automatic test_reset();
        rst = 1'b1; stray = 1'b0;
        drw_i = 2'b10; iaddr_i = 32'h1234_5678; daddr_i = 32'h8765_4321; dout_i = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cpu_stall_o, bus.mem_req, bus.mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b exp 100", {cpu_stall_o, bus.mem_req, bus.mem_we});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, iin_o, din_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h exp 0", {bus.mem_addr, bus.mem_wdata, iin_o, din_o});
        end
        exp_iin = '0; exp_din = '0; buf_v = 1'b0;
        rst = 1'b0;
        run_step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3C01_0010, 1, 1);
    endtask
    task automatic test_read();
        run_step(1'b0, 2'b01, 32'hF020_0000, 32'h1111_1111, 32'h4, 32'h0000_00A5, 32'h2402_0001, 1, 1);
        run_step(1'b0, 2'b01, 32'hF020_0004, 32'h0, 32'h8, 32'h0000_005A, 32'h2403_0002, 2, 3);
    endtask
    task automatic test_write();
        run_step(1'b0, 2'b10, 32'hF030_0000, 32'hDEAD_BEEF, 32'hC, 32'h7777_7777, 32'hAC01_0000, 3, 1);
        run_step(1'b0, 2'b11, 32'hF030_0004, 32'hCAFE_F00D, 32'h10, 32'h6666_6666, 32'h0800_0000, 1, 2);
    endtask
    task automatic test_reset_mid();
        stray = 1'b0;
        drw_i = 2'b01; daddr_i = 32'hF040_0000; iaddr_i = 32'h14;
        rdat_d = 32'h9999_9999; rdat_f = 32'h5555_5555; has_data = 1'b1; lat_d = 1; lat_f = 0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hF040_0000) begin
            n_fail++;
            $display("FAIL mid_data_req: got %b/%h exp 1/f0400000", bus.mem_req, bus.mem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, cpu_stall_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_rst_ctl: got %b exp 01", {bus.mem_req, cpu_stall_o});
        end
        n_cmp++;
        if ({din_o, iin_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_rst_regs: got %h exp 0", {din_o, iin_o});
        end
        exp_iin = '0; exp_din = '0; buf_v = 1'b0;
        rst = 1'b0;
        run_step(1'b1, 2'b01, 32'hF040_0000, 32'h0, 32'h14, 32'h9999_9999, 32'h3C05_0005, 1, 2);
    endtask
    task automatic test_ibuf();
        run_step(1'b0, 2'b00, 32'h0, 32'h0, 32'h100, 32'h0, 32'hA000_0100, 1, 2);
        run_step(1'b0, 2'b00, 32'h0, 32'h0, 32'h100, 32'h0, 32'hB000_0100, 1, 2);
        run_step(1'b0, 2'b10, 32'h100, 32'h1234_0000, 32'h100, 32'h0, 32'hC000_0100, 1, 1);
        run_step(1'b0, 2'b01, 32'h200, 32'h0, 32'h100, 32'h0000_0F0F, 32'hD000_0100, 2, 1);
    endtask
    task automatic test_back_to_back();
        logic [1:0]  drw;
        logic [31:0] ia;
        logic [31:0] da;
        for (int i = 0; i < 60; i++) begin
            drw = 2'($urandom_range(0, 3));
            ia  = 32'h100 + 32'(4 * $urandom_range(0, 3));
            da  = $urandom_range(0, 1) ? 32'h100 + 32'(4 * $urandom_range(0, 3)) : $urandom;
            run_step(1'b0, drw, da, $urandom, ia, $urandom, $urandom,
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end
    endtask
    initial begin
        test_reset();
        test_read();
        test_write();
        test_reset_mid();
        test_ibuf();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
